// File: rtl/seed_pkg.sv
// seed_pkg: shared SEED widths, FSM state type and S-box arithmetic.
// S1/S2 are built as affine maps of the GF(2^8) inverse (poly 0x163).
package seed_pkg;

  localparam int NROUND = 16;
  localparam int W32    = 32;
  localparam int W64    = 64;
  localparam int W128   = 128;
  localparam int RW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [RW-1:0] LAST_RND = RW'(NROUND - 1);

  // x^8 = x^6 + x^5 + x + 1
  localparam logic [7:0] GF_RED = 8'h63;

  // Column k (bits 8k+7:8k) is the image of inverse bit k.
  // These fold the x^8 / x^4 Frobenius into the affine matrix.
  localparam logic [63:0] S1_COL =
    64'h5bc0ded69443e02c;
  localparam logic [63:0] S2_COL =
    64'h351ad525dd6821d0;
  localparam logic [7:0] S1_CST = 8'ha9;
  localparam logic [7:0] S2_CST = 8'h38;

  localparam logic [7:0] M0 = 8'hfc;
  localparam logic [7:0] M1 = 8'hf3;
  localparam logic [7:0] M2 = 8'hcf;
  localparam logic [7:0] M3 = 8'h3f;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^
           (sh[7] ? GF_RED : 8'h00);
    end
    return acc;
  endfunction

  // a^254; maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(
    input logic [7:0]  v,
    input logic [63:0] col,
    input logic [7:0]  cst
  );
    logic [7:0] r;
    r = cst;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) r = r ^ col[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox1(
    input logic [7:0] x
  );
    return affine(gf_inv(x), S1_COL, S1_CST);
  endfunction

  function automatic logic [7:0] sbox2(
    input logic [7:0] x
  );
    return affine(gf_inv(x), S2_COL, S2_CST);
  endfunction

endpackage

// File: rtl/seed_f_function.sv
// seed_f_function: combinational 64-bit SEED round function F.
// Ports: r_i right half, key_i {K0,K1}, f_o {T0,T1}.
module seed_f_function
  import seed_pkg::*;
(
  input  logic [W64-1:0] r_i,
  input  logic [W64-1:0] key_i,
  output logic [W64-1:0] f_o
);

  logic [W32-1:0] t0a, t1a;
  logic [W32-1:0] t1b, t0b, t0c;
  logic [W32-1:0] t1c, t1d, t0d;
  logic [W32-1:0] g1_in;

  assign t0a   = r_i[63:32] ^ key_i[63:32];
  assign t1a   = r_i[31:0] ^ key_i[31:0];
  assign g1_in = t1a ^ t0a;

  seed_g u_g1 (
    .x_i (g1_in),
    .y_o (t1b)
  );

  assign t0b = t0a + t1b;

  seed_g u_g2 (
    .x_i (t0b),
    .y_o (t0c)
  );

  assign t1c = t1b + t0c;

  seed_g u_g3 (
    .x_i (t1c),
    .y_o (t1d)
  );

  assign t0d = t0c + t1d;
  assign f_o = {t0d, t1d};

endmodule

// File: rtl/seed_g.sv
// seed_g: combinational SEED G function (S-boxes plus byte mixing).
// Ports: x_i 32-bit word in, y_o 32-bit word out.
module seed_g
  import seed_pkg::*;
(
  input  logic [W32-1:0] x_i,
  output logic [W32-1:0] y_o
);

  logic [7:0] a, b, c, d;
  logic [7:0] z0, z1, z2, z3;

  assign a = sbox1(x_i[7:0]);
  assign b = sbox2(x_i[15:8]);
  assign c = sbox1(x_i[23:16]);
  assign d = sbox2(x_i[31:24]);

  assign z0 = (a & M0) ^ (b & M1) ^
              (c & M2) ^ (d & M3);
  assign z1 = (a & M1) ^ (b & M2) ^
              (c & M3) ^ (d & M0);
  assign z2 = (a & M2) ^ (b & M3) ^
              (c & M0) ^ (d & M1);
  assign z3 = (a & M3) ^ (b & M0) ^
              (c & M1) ^ (d & M2);

  assign y_o = {z3, z2, z1, z0};

endmodule

// File: rtl/seed_cipher_core.sv
// seed_cipher_core: iterative 16-round SEED Feistel datapath.
// Ports: i_Clk/i_Rst(async low); i_fStart,i_fDec,i_Text in;
// o_Text,o_fDone,o_fBusy out; o_Key* drive the key schedule,
// i_RoundKey returns {K0,K1} for o_KeyRound.
module seed_cipher_core
  import seed_pkg::*;
(
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_fStart,
  input  logic            i_fDec,
  input  logic [W128-1:0] i_Text,
  output logic [W128-1:0] o_Text,
  output logic            o_fDone,
  output logic            o_fBusy,
  output logic            o_KeyStart,
  output logic            o_KeyDec,
  output logic            o_KeyRunning,
  output logic [RW-1:0]   o_KeyRound,
  input  logic [W64-1:0]  i_RoundKey
);

  state_e          state_q;
  logic [W64-1:0]  l_q, r_q;
  logic [RW-1:0]   rnd_q;
  logic            dec_q;
  logic            done_q;
  logic [W128-1:0] text_q;
  logic [W64-1:0]  f_w;
  logic [W64-1:0]  mix_w;

  seed_f_function u_f (
    .r_i   (r_q),
    .key_i (i_RoundKey),
    .f_o   (f_w)
  );

  assign mix_w = l_q ^ f_w;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      text_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (i_fStart) begin
            l_q     <= i_Text[127:64];
            r_q     <= i_Text[63:0];
            dec_q   <= i_fDec;
            rnd_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (rnd_q == LAST_RND) begin
            // last round skips the half swap
            text_q  <= {mix_w, r_q};
            rnd_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            l_q   <= r_q;
            r_q   <= mix_w;
            rnd_q <= rnd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Text       = text_q;
  assign o_fDone      = done_q;
  assign o_fBusy      = (state_q == RUN);
  assign o_KeyRunning = (state_q == RUN);
  assign o_KeyRound   = rnd_q;
  assign o_KeyDec     = dec_q;
  assign o_KeyStart   = i_fStart & (state_q != RUN);

endmodule

// File: tb/tb_seed_cipher_core.sv
// tb_seed_cipher_core: known-answer and timing checks for the core.
// Acts as the key schedule, feeding round keys by o_KeyRound.
module tb_seed_cipher_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_fStart;
  logic         i_fDec;
  logic [127:0] i_Text;
  logic [127:0] o_Text;
  logic         o_fDone;
  logic         o_fBusy;
  logic         o_KeyStart;
  logic         o_KeyDec;
  logic         o_KeyRunning;
  logic [3:0]   o_KeyRound;
  logic [63:0]  i_RoundKey;

  logic [63:0] rk_tab [16];
  logic [7:0]  s1_tab [256];
  logic [7:0]  s2_tab [256];

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [7:0] S1_C [8] = '{
    8'h2c, 8'he0, 8'h43, 8'h94,
    8'hd6, 8'hde, 8'hc0, 8'h5b};
  localparam logic [7:0] S2_C [8] = '{
    8'hd0, 8'h21, 8'h68, 8'hdd,
    8'h25, 8'hd5, 8'h1a, 8'h35};

  typedef struct {
    logic [127:0] key;
    logic [127:0] txt;
    logic         dec;
    logic [127:0] exp;
    string        nm;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  assign i_RoundKey =
    rk_tab[o_KeyDec ? 4'd15 - o_KeyRound : o_KeyRound];

  seed_cipher_core dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .i_fStart     (i_fStart),
    .i_fDec       (i_fDec),
    .i_Text       (i_Text),
    .o_Text       (o_Text),
    .o_fDone      (o_fDone),
    .o_fBusy      (o_fBusy),
    .o_KeyStart   (o_KeyStart),
    .o_KeyDec     (o_KeyDec),
    .o_KeyRunning (o_KeyRunning),
    .o_KeyRound   (o_KeyRound),
    .i_RoundKey   (i_RoundKey)
  );

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // carry-less product, then reduce by 0x163
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int j = 14; j >= 8; j--)
      if (p[j]) p = p ^ (15'h163 << (j - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] g_fn(
    input logic [31:0] x
  );
    logic [7:0] a, b, c, d;
    a = s1_tab[x[7:0]];
    b = s2_tab[x[15:8]];
    c = s1_tab[x[23:16]];
    d = s2_tab[x[31:24]];
    return ({4{a}} & 32'h3fcff3fc) ^
           ({4{b}} & 32'hfc3fcff3) ^
           ({4{c}} & 32'hf3fc3fcf) ^
           ({4{d}} & 32'hcff3fc3f);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, v1, v2;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01)
          inv = 8'(y);
      v1 = 8'ha9;
      v2 = 8'h38;
      for (int k = 0; k < 8; k++)
        if (inv[k]) begin
          v1 = v1 ^ S1_C[k];
          v2 = v2 ^ S2_C[k];
        end
      s1_tab[x] = v1;
      s2_tab[x] = v2;
    end
  endtask

  task automatic ks_load(input logic [127:0] key);
    logic [63:0] ab, cd;
    logic [31:0] kc;
    ab = key[127:64];
    cd = key[63:0];
    kc = 32'h9e3779b9;
    for (int i = 0; i < 16; i++) begin
      rk_tab[i] = {
        g_fn(ab[63:32] + cd[63:32] - kc),
        g_fn(ab[31:0] - cd[31:0] + kc)};
      if (i % 2 == 0) ab = {ab[7:0], ab[63:8]};
      else            cd = {cd[55:0], cd[63:56]};
      kc = {kc[30:0], kc[31]};
    end
  endtask

  // called at a negedge; returns at the negedge of T+1
  task automatic start_blk(
    input logic [127:0] key,
    input logic [127:0] txt,
    input logic         dec
  );
    ks_load(key);
    i_fStart = 1'b1;
    i_fDec   = dec;
    i_Text   = txt;
    #1 chk("keystart", 128'(o_KeyStart), 128'(1'b1));
    @(negedge clk);
    i_fStart = 1'b0;
  endtask

  // walks T+1..T+16, returns at the negedge of the DONE cycle
  task automatic track(
    input logic [127:0] exp,
    input logic         dec,
    input logic [127:0] hold,
    input bit           poke
  );
    for (int k = 1; k <= 16; k++) begin
      chk("busy", 128'(o_fBusy), 128'(1'b1));
      chk("keyrun", 128'(o_KeyRunning), 128'(1'b1));
      chk("keyround", 128'(o_KeyRound), 128'(k - 1));
      chk("keydec", 128'(o_KeyDec), 128'(dec));
      chk("done_early", 128'(o_fDone), 128'(1'b0));
      chk("text_hold", o_Text, hold);
      if (poke && (k == 4 || k == 10)) begin
        i_fStart = 1'b1;
        i_Text   = ~exp;
        i_fDec   = ~dec;
        #1 chk("keystart_run", 128'(o_KeyStart),
               128'(1'b0));
      end
      @(negedge clk);
      i_fStart = 1'b0;
    end
    chk("done", 128'(o_fDone), 128'(1'b1));
    chk("text", o_Text, exp);
    chk("busy_done", 128'(o_fBusy), 128'(1'b0));
    chk("keyrun_done", 128'(o_KeyRunning), 128'(1'b0));
    chk("keyround_done", 128'(o_KeyRound), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] last;
    bit           bad;

    vecs[0] = '{128'h0,
      128'h000102030405060708090a0b0c0d0e0f, 1'b0,
      128'h5ebac6e0054e166819aff1cc6d346cdb, "enc_k0"};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
      128'h0, 1'b0,
      128'hc11f22f20140505084483597e4370f43, "enc_k1"};
    vecs[2] = '{128'h0,
      128'h5ebac6e0054e166819aff1cc6d346cdb, 1'b1,
      128'h000102030405060708090a0b0c0d0e0f, "dec_k0"};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f,
      128'hc11f22f20140505084483597e4370f43, 1'b1,
      128'h0, "dec_k1"};

    build_sbox();
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    i_fStart = 1'b0;
    i_fDec   = 1'b0;
    i_Text   = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_text", o_Text, 128'h0);
    chk("rst_done", 128'(o_fDone), 128'(1'b0));
    chk("rst_busy", 128'(o_fBusy), 128'(1'b0));
    chk("rst_keydec", 128'(o_KeyDec), 128'(1'b0));
    chk("rst_keyrun", 128'(o_KeyRunning), 128'(1'b0));
    chk("rst_keyround", 128'(o_KeyRound), 128'(0));

    rst_n = 1'b1;
    @(negedge clk);
    last = '0;

    for (int v = 0; v < 4; v++) begin
      start_blk(vecs[v].key, vecs[v].txt, vecs[v].dec);
      track(vecs[v].exp, vecs[v].dec, last, 1'b0);
      last = vecs[v].exp;
      @(negedge clk);
      chk({vecs[v].nm, "_idle_done"},
          128'(o_fDone), 128'(1'b0));
    end

    // second start lands in the DONE cycle of the first
    start_blk(vecs[0].key, vecs[0].txt, 1'b0);
    track(vecs[0].exp, 1'b0, last, 1'b0);
    start_blk(vecs[1].key, vecs[1].txt, 1'b0);
    track(vecs[1].exp, 1'b0, vecs[0].exp, 1'b1);
    last = vecs[1].exp;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_text", o_Text, last);
      chk("idle_done", 128'(o_fDone), 128'(1'b0));
      chk("idle_keyrun", 128'(o_KeyRunning),
          128'(1'b0));
    end

    // reset at round 7 of a decrypt
    start_blk(vecs[3].key, vecs[3].txt, 1'b1);
    repeat (7) @(negedge clk);
    chk("pre_rst_round", 128'(o_KeyRound), 128'(7));
    chk("pre_rst_keydec", 128'(o_KeyDec), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_text", o_Text, 128'h0);
    chk("mid_rst_done", 128'(o_fDone), 128'(1'b0));
    chk("mid_rst_busy", 128'(o_fBusy), 128'(1'b0));
    chk("mid_rst_keydec", 128'(o_KeyDec), 128'(1'b0));
    chk("mid_rst_keyrun", 128'(o_KeyRunning),
        128'(1'b0));
    chk("mid_rst_keyround", 128'(o_KeyRound), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (o_fDone || o_fBusy) bad = 1'b1;
    end
    chk("post_rst_quiet", 128'(bad), 128'(1'b0));

    start_blk(vecs[0].key, vecs[0].txt, 1'b0);
    track(vecs[0].exp, 1'b0, 128'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
